// File: rtl/proc_pkg.sv
// Shared processor datapath package: word type and default word constants.
package proc_pkg;

  localparam int WORD_W = 16;

  typedef logic [WORD_W-1:0] word_t;

  localparam word_t WORD_RESET = 16'h0000;

endpackage : proc_pkg

// File: rtl/reg_component_lane.sv
// reg_lane: one byte-lane storage flop with load enable and asynchronous
// active-high reset. Only built when REG_COMPONENT_BYTE_EN_EN is defined,
// since reg_component is a flat register otherwise.
`ifdef REG_COMPONENT_BYTE_EN_EN
module reg_lane #(
  parameter int                LANE_W    = 8,
  parameter logic [LANE_W-1:0] RESET_VAL = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              en,
  input  logic [LANE_W-1:0] d,
  output logic [LANE_W-1:0] q
);

  logic [LANE_W-1:0] r_q;

  // Lane storage: reset wins, otherwise load on enable, otherwise hold.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_q <= RESET_VAL;
    end else if (en) begin
      r_q <= d;
    end else begin
      r_q <= r_q;
    end
  end

  assign q = r_q;

endmodule : reg_lane
`endif

// File: rtl/reg_component.sv
// reg_component: WIDTH-bit datapath storage register with write enable and
// asynchronous active-high reset. Output comes straight from the flops.
// Optional feature macro: REG_COMPONENT_BYTE_EN_EN adds per-byte write
// enables (byte_en), one bit per 8-bit lane, last lane possibly partial.
module reg_component
  import proc_pkg::*;
#(
  parameter int               WIDTH       = WORD_W,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     write,
`ifdef REG_COMPONENT_BYTE_EN_EN
  input  logic [(WIDTH+7)/8-1:0]   byte_en,
`endif
  input  logic [WIDTH-1:0]         in,
  output logic [WIDTH-1:0]         out
);

`ifdef REG_COMPONENT_BYTE_EN_EN

  localparam int NUM_LANES = (WIDTH + 7) / 8;

  logic [WIDTH-1:0] w_out;

  // One independently enabled flop group per byte lane; the top lane
  // narrows when WIDTH is not a multiple of 8.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    localparam int LO = 8 * i;
    localparam int LW = ((WIDTH - LO) >= 8) ? 8 : (WIDTH - LO);

    reg_lane #(
      .LANE_W    (LW),
      .RESET_VAL (RESET_VALUE[LO +: LW])
    ) u_lane (
      .clock (clock),
      .reset (reset),
      .en    (write & byte_en[i]),
      .d     (in[LO +: LW]),
      .q     (w_out[LO +: LW])
    );
  end

  assign out = w_out;

`else

  logic [WIDTH-1:0] r_out;

  // Whole-word storage: reset wins, otherwise load on write, otherwise hold.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_out <= RESET_VALUE;
    end else if (write) begin
      r_out <= in;
    end else begin
      r_out <= r_out;
    end
  end

  assign out = r_out;

`endif

endmodule : reg_component

// File: tb/tb_reg_component.sv
// Self-checking bench for reg_component: a table of single-cycle vectors
// plus hand-written sequences for asynchronous reset and byte enables.
module tb_reg_component;
  import proc_pkg::*;

  localparam int NB = (WORD_W + 7) / 8;

  logic    clock;
  logic    reset;
  logic    write;
  word_t   in;
  word_t   out;
`ifdef REG_COMPONENT_BYTE_EN_EN
  logic [NB-1:0] byte_en;
`endif

  int checks;
  int errors;

  reg_component #(
    .WIDTH       (WORD_W),
    .RESET_VALUE (WORD_RESET)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .write   (write),
`ifdef REG_COMPONENT_BYTE_EN_EN
    .byte_en (byte_en),
`endif
    .in      (in),
    .out     (out)
  );

  // Free-running clock, 10 time-unit period.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic  rst;
    logic  wr;
    word_t din;
    word_t exp;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input word_t act, input word_t exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: out=%h expected=%h", name, act, exp);
    end
  endtask

  // Drive one vector on the falling edge, then sample just after the rising edge.
  task automatic cycle(input logic rst, input logic wr, input word_t din);
    @(negedge clock);
    reset = rst;
    write = wr;
    in    = din;
    @(posedge clock);
    #1;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset   = 1'b1;
    write   = 1'b0;
    in      = 16'h0000;
`ifdef REG_COMPONENT_BYTE_EN_EN
    byte_en = {NB{1'b1}};
`endif

    // Reset, reset priority, write after reset, hold, data patterns.
    vecs[0]  = '{1'b1, 1'b0, 16'h0006, 16'h0000};
    vecs[1]  = '{1'b1, 1'b1, 16'h00FF, 16'h0000};
    vecs[2]  = '{1'b1, 1'b1, 16'h00FF, 16'h0000};
    vecs[3]  = '{1'b0, 1'b1, 16'h000F, 16'h000F};
    vecs[4]  = '{1'b0, 1'b1, 16'hA5A5, 16'hA5A5};
    vecs[5]  = '{1'b1, 1'b0, 16'h000F, 16'h0000};
    vecs[6]  = '{1'b0, 1'b0, 16'h000F, 16'h0000};
    vecs[7]  = '{1'b0, 1'b1, 16'h1234, 16'h1234};
    vecs[8]  = '{1'b0, 1'b0, 16'hFFFF, 16'h1234};
    vecs[9]  = '{1'b0, 1'b0, 16'hFFFF, 16'h1234};
    vecs[10] = '{1'b0, 1'b0, 16'hFFFF, 16'h1234};
    vecs[11] = '{1'b0, 1'b1, 16'hFFFF, 16'hFFFF};
    vecs[12] = '{1'b0, 1'b1, 16'h0000, 16'h0000};
    vecs[13] = '{1'b0, 1'b1, 16'hBEEF, 16'hBEEF};

    // Table pass.
    for (int i = 0; i < 14; i++) begin
      cycle(vecs[i].rst, vecs[i].wr, vecs[i].din);
      check($sformatf("vec%0d", i), out, vecs[i].exp);
    end

    // No combinational path: change in with write high between edges.
    @(negedge clock);
    write = 1'b1;
    in    = 16'h5555;
    #1;
    check("no_bypass", out, 16'hBEEF);
    @(posedge clock);
    #1;
    check("no_bypass_load", out, 16'h5555);

    // Async reset mid-operation: reload BEEF, pulse reset between edges.
    cycle(1'b0, 1'b1, 16'hBEEF);
    check("pre_async", out, 16'hBEEF);
    @(negedge clock);
    write = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    check("async_assert", out, 16'h0000);
    reset = 1'b0;
    #1;
    check("async_release", out, 16'h0000);
    @(posedge clock);
    #1;
    check("async_hold", out, 16'h0000);

`ifdef REG_COMPONENT_BYTE_EN_EN
    // Byte-lane writes from a cleared register.
    cycle(1'b1, 1'b0, 16'h0000);
    check("be_reset", out, 16'h0000);
    @(negedge clock);
    reset   = 1'b0;
    write   = 1'b1;
    byte_en = 2'b10;
    in      = 16'hABCD;
    @(posedge clock);
    #1;
    check("be_hi", out, 16'hAB00);
    @(negedge clock);
    byte_en = 2'b01;
    in      = 16'h1234;
    @(posedge clock);
    #1;
    check("be_lo", out, 16'hAB34);
    @(negedge clock);
    write   = 1'b0;
    byte_en = 2'b11;
    in      = 16'hFFFF;
    @(posedge clock);
    #1;
    check("be_write_off", out, 16'hAB34);
    @(negedge clock);
    write   = 1'b1;
    byte_en = 2'b00;
    @(posedge clock);
    #1;
    check("be_none", out, 16'hAB34);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_reg_component
